multicycle_control: RTL
=======================

# multicycle_control

Main control FSM for the multi-cycle RISC-V core. It sequences one shared ALU, one unified instruction/data memory and the register file across the FETCH/DECODE/EXECUTE/MEM/WB phases. It drives `ALUOp` into the ALU control decoder, which turns `ALUOp`/`Funct7`/`Funct3` into `ALUCtrl`. It also handles the memory ready handshake, traps on unsupported opcodes, and counts retired instructions.

## Interface
- `CNT_W`, 32 — width of the retired-instruction counter.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `reset`  in  1  — synchronous, active-high.
- `Opcode`  in  7  — IR[6:0]; sampled in DECODE and later states.
- `Zero`  in  1  — ALU zero flag; used only by the external PC-write logic, listed for completeness.
- `MemReady`  in  1  — memory completed the current `MemRead`/`MemWrite` request this cycle.
- `PCWrite`  out  1  — unconditional PC load.
- `PCWriteCond`  out  1  — PC load when `Zero`=1 (beq).
- `IorD`  out  1  — memory address select: 0 = PC, 1 = ALUOut.
- `MemRead`  out  1  — read request.
- `MemWrite`  out  1  — write request.
- `IRWrite`  out  1  — load the instruction register.
- `MemtoReg`  out  1  — write-back source: 0 = ALUOut, 1 = MDR.
- `RegWrite`  out  1  — register file write enable.
- `ALUSrcA`  out  1  — ALU A source: 0 = PC, 1 = rs1.
- `ALUSrcB`  out  2  — ALU B source: 00 = rs2, 01 = const 4, 10 = imm.
- `ALUOp`  out  2  — 00 = add, 01 = sub, 10 = decode from funct fields.
- `PCSource`  out  1  — PC input: 0 = ALU result, 1 = ALUOut.
- `Illegal`  out  1  — sticky trap flag.
- `InstrRetired`  out  CNT_W  — retired-instruction count.

## Operation
- Supported opcodes:
  - R-type 0110011
  - ld 0000011
  - sd 0100011
  - beq 1100011
- State register transitions:
  - FETCH: `MemRead`=1, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, `ALUOp`=00. `IRWrite`=`PCWrite`=`MemReady`. On `MemReady` go to DECODE, otherwise stay.
  - DECODE: `ALUSrcA`=0, `ALUSrcB`=10, `ALUOp`=00 (branch target into ALUOut). Next state by opcode: R → EXEC, ld/sd → MEMADDR, beq → BRANCH, any other → TRAP.
  - EXEC: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=10. Next: ALUWB.
  - ALUWB: `RegWrite`=1, `MemtoReg`=0. Next: FETCH.
  - MEMADDR: `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=00. Next: MEMRD (ld) or MEMWR (sd).
  - MEMRD: `MemRead`=1, `IorD`=1. Wait for `MemReady`, then MEMWB.
  - MEMWB: `RegWrite`=1, `MemtoReg`=1. Next: FETCH.
  - MEMWR: `MemWrite`=1, `IorD`=1. Wait for `MemReady`, then FETCH.
  - BRANCH: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=01, `PCWriteCond`=1, `PCSource`=1. Next: FETCH.
  - TRAP: `Illegal`=1, all strobes 0. Stays in TRAP until `reset`.
- Any output not listed for a state is 0.
- `InstrRetired` increments by 1 on each exit to FETCH from ALUWB, MEMWB, MEMWR (with `MemReady`) or BRANCH. It wraps modulo 2^CNT_W.
- `MemReady` is ignored in states that issue no memory request.
- `MemRead`/`MemWrite` are held steady until `MemReady` is sampled high. There is no timeout.

## Timing
- Outputs are combinational from the state register, plus `MemReady` gating in FETCH. The state register and counter update on the `clk` rising edge.
- While `reset`=1:
  - All write/request strobes are forced to 0: `PCWrite`, `PCWriteCond`, `IRWrite`, `RegWrite`, `MemRead`, `MemWrite`.
  - State loads FETCH, `InstrRetired` loads 0, and `Illegal` reads 0.
- After reset is released, FETCH is active in the first cycle.
- Reset asserted mid-instruction aborts it on the next edge. There is no retire and no write from the aborted instruction after that edge.
- Latency with `MemReady` high on the first request cycle:
  - R-type: 4 cycles
  - ld: 5 cycles
  - sd: 4 cycles
  - beq: 3 cycles
- Each wait cycle on `MemReady` adds exactly 1 cycle.

## Structure
- Shared package `riscv_ctrl_pkg` holds:
  - the state enum;
  - opcode localparams (`OP_RTYPE`, `OP_LOAD`, `OP_STORE`, `OP_BRANCH`);
  - `ALUOp` encodings (`ALUOP_ADD`=00, `ALUOP_SUB`=01, `ALUOP_FUNCT`=10);
  - `ALUSrcB` encodings.
- Single module with no sub-module. The next-state and output decode are two combinational processes beside the state/counter register process.

## Test plan
- Reset held 3 cycles with `MemReady`=1 → all strobes 0 and `InstrRetired`=0. After release, `MemRead`=1 and `IRWrite`=1 in the first cycle.
- `Opcode`=0110011, `MemReady`=1 → states FETCH, DECODE, EXEC, ALUWB. `ALUOp`=10 in EXEC, `RegWrite`=1 in ALUWB, and `InstrRetired` goes 0 → 1.
- ld with `MemReady` low for 2 cycles in MEMRD → `MemRead`=1 and `IorD`=1 held for 3 cycles. Total 7 cycles, and `MemtoReg`=1 in MEMWB.
- beq → 3 cycles, with `ALUOp`=01, `PCWriteCond`=1 and `PCSource`=1 in BRANCH. Then sd: `MemWrite`=1 for exactly 1 cycle. Counter = 2.
- `Opcode`=1111111 → TRAP after DECODE, with `Illegal`=1 and all strobes 0 for 10+ cycles. `reset` clears it.
- Preload the counter with CNT_W=4 and retire 16 instructions → `InstrRetired` wraps to 0. Reset asserted in MEMWR → no `MemWrite` after the edge.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_ctrl_pkg
//  Description : Shared definitions for the multi-cycle RISC-V main control:
//                state encoding, supported opcodes, ALUOp and ALUSrcB codes.
//  Ports       : (package - none)
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_EXEC    = 4'd2,
        ST_ALUWB   = 4'd3,
        ST_MEMADDR = 4'd4,
        ST_MEMRD   = 4'd5,
        ST_MEMWB   = 4'd6,
        ST_MEMWR   = 4'd7,
        ST_BRANCH  = 4'd8,
        ST_TRAP    = 4'd9
    } state_t;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUSRCB_RS2  = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM  = 2'b10;

endpackage : riscv_ctrl_pkg
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control
//  Description : Main control FSM of the multi-cycle RISC-V core. Sequences
//                FETCH/DECODE/EXECUTE/MEM/WB over one shared ALU, unified
//                memory and register file; traps on unsupported opcodes and
//                counts retired instructions.
//  Ports       : clk, reset (sync, active-high)
//                Opcode[6:0], Zero, MemReady            - inputs
//                PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
//                MemtoReg, RegWrite, ALUSrcA, ALUSrcB[1:0], ALUOp[1:0],
//                PCSource, Illegal                        - datapath controls
//                InstrRetired[CNT_W-1:0]                  - retire counter
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control
    import riscv_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       Opcode,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic             PCSource,
    output logic             Illegal,
    output logic [CNT_W-1:0] InstrRetired
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_retire;
    logic [CNT_W-1:0] r_retired;

    // Zero is consumed by the external PC-write logic only.
    logic w_unused_zero;
    assign w_unused_zero = Zero;

    // ------------------------------------------------------------------------
    // Next-state decode and retire detection
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_retire    = 1'b0;
        case (r_state)
            ST_FETCH: begin
                if (MemReady) w_state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                case (Opcode)
                    OP_RTYPE:           w_state_nxt = ST_EXEC;
                    OP_LOAD, OP_STORE:  w_state_nxt = ST_MEMADDR;
                    OP_BRANCH:          w_state_nxt = ST_BRANCH;
                    default:            w_state_nxt = ST_TRAP;
                endcase
            end
            ST_EXEC:    w_state_nxt = ST_ALUWB;
            ST_ALUWB: begin
                w_state_nxt = ST_FETCH;
                w_retire    = 1'b1;
            end
            // Only ld/sd reach MEMADDR, so anything not a load is the store.
            ST_MEMADDR: w_state_nxt = (Opcode == OP_LOAD) ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD: begin
                if (MemReady) w_state_nxt = ST_MEMWB;
            end
            ST_MEMWB: begin
                w_state_nxt = ST_FETCH;
                w_retire    = 1'b1;
            end
            ST_MEMWR: begin
                if (MemReady) begin
                    w_state_nxt = ST_FETCH;
                    w_retire    = 1'b1;
                end
            end
            ST_BRANCH: begin
                w_state_nxt = ST_FETCH;
                w_retire    = 1'b1;
            end
            ST_TRAP:    w_state_nxt = ST_TRAP;
            default:    w_state_nxt = ST_FETCH;
        endcase
    end

    // ------------------------------------------------------------------------
    // Output decode (Moore, plus MemReady gating of the fetch strobes)
    // ------------------------------------------------------------------------
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = ALUSRCB_RS2;
        ALUOp       = ALUOP_ADD;
        PCSource    = 1'b0;
        Illegal     = 1'b0;
        case (r_state)
            ST_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = ALUSRCB_FOUR;
                IRWrite = MemReady;
                PCWrite = MemReady;
            end
            ST_DECODE: begin
                ALUSrcB = ALUSRCB_IMM;
            end
            ST_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
            end
            ST_ALUWB: begin
                RegWrite = 1'b1;
            end
            ST_MEMADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = ALUSRCB_IMM;
            end
            ST_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            ST_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            ST_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            ST_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = 1'b1;
            end
            ST_TRAP: begin
                Illegal = 1'b1;
            end
            default: ;
        endcase
        // Reset masks every side effect in the same cycle so an aborted
        // instruction cannot complete a write before the edge lands.
        if (reset) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IRWrite     = 1'b0;
            RegWrite    = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            Illegal     = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // State and retire counter registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_FETCH;
            r_retired <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_retire) r_retired <= r_retired + CNT_W'(1);
        end
    end

    assign InstrRetired = r_retired;

endmodule : multicycle_control
`default_nettype wire
